// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//
// Read-side controller for async_fifo, running entirely in the read clock
// domain. Words are popped from the FIFO read port into a 2-entry register
// buffer and presented downstream on a valid/ready stream. A running count
// of completed downstream handshakes is kept. A flush request discards the
// buffer and drains the FIFO until it reports empty, then pulses flush_done.
//
// Ports:
//   rclk        read-domain clock, rising edge
//   rrst        asynchronous active-high reset
//   fifo_rdata  FIFO head word (valid while fifo_rempty = 0)
//   fifo_rempty FIFO empty flag, synchronous to rclk
//   fifo_rinc   pop strobe towards the FIFO
//   out_data    head word of the output buffer
//   out_valid   out_data is valid
//   out_ready   downstream accepts out_data at the clock edge
//   flush       single-cycle flush request
//   flush_done  one-cycle pulse after the flush has drained the FIFO
//   word_count  number of completed out_valid & out_ready handshakes
// ---------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             flush_done,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             head_q, head_d;
    logic [DSIZE-1:0] buf_q [2];
    logic [DSIZE-1:0] buf_d [2];
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             flush_done_q, flush_done_d;

    logic             push;
    logic             pop;
    logic             tail;

    // Outputs derive only from registered state (plus fifo_rempty/rrst for
    // the pop strobe), so out_valid never depends on out_ready.
    assign out_valid  = (state_q == RUN) && (cnt_q != 2'd0);
    assign out_data   = buf_q[head_q];
    assign flush_done = flush_done_q;
    assign word_count = word_count_q;

    // While draining, every available word is popped and thrown away.
    assign fifo_rinc  = !rrst && !fifo_rempty &&
                        ((state_q == FLUSH) || (cnt_q != 2'd2));

    assign pop  = out_valid && out_ready;
    // A word popped on the edge that starts a flush is discarded.
    assign push = fifo_rinc && (state_q == RUN) && !flush;
    // Tail slot is head + cnt (mod 2); a push only happens with cnt < 2.
    assign tail = head_q ^ cnt_q[0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        head_d       = head_q;
        buf_d        = buf_q;
        flush_done_d = 1'b0;
        // A handshake on the flush edge still counts.
        word_count_d = word_count_q + {{(CNT_W-1){1'b0}}, pop};

        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                    cnt_d   = 2'd0;
                    head_d  = 1'b0;
                end else begin
                    if (push) begin
                        buf_d[tail] = fifo_rdata;
                    end
                    if (pop) begin
                        head_d = ~head_q;
                    end
                    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
                end
            end
            FLUSH: begin
                if (fifo_rempty) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q      <= RUN;
            cnt_q        <= 2'd0;
            head_q       <= 1'b0;
            word_count_q <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            head_q       <= head_d;
            word_count_q <= word_count_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Buffer entries, one register per slot.
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge rclk or posedge rrst) begin
            if (rrst) begin
                buf_q[gi] <= '0;
            end else begin
                buf_q[gi] <= buf_d[gi];
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

    localparam int DSIZE = 8;
    localparam int CNT_W = 4;

    logic             rclk;
    logic             rrst;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [DSIZE-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic             flush_done;
    logic [CNT_W-1:0] word_count;

    fifo_read_ctrl #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_rdata (fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .fifo_rinc  (fifo_rinc),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .word_count (word_count)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    int checks = 0;
    int errors = 0;

    logic [DSIZE-1:0] fifo_q [$];   // environment: contents of async_fifo
    logic [DSIZE-1:0] sb [$];       // scoreboard: words expected downstream
    int total_pops = 0;

    // reference model state
    int m_cnt  = 0;
    int m_wc   = 0;
    bit m_flush = 0;
    bit m_done  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, capture the pop
    // strobe before the rising edge, and let the FIFO model consume the word.
    task automatic cycle(input bit rdy, input bit fl);
        bit rinc_s;
        @(negedge rclk);
        out_ready   = rdy;
        flush       = fl;
        fifo_rempty = (fifo_q.size() == 0);
        fifo_rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
        #3;
        rinc_s = fifo_rinc;
        @(posedge rclk);
        if (rinc_s) begin
            total_pops++;
            if (fifo_q.size() == 0) begin
                chk("underflow", 1, 0);
            end else begin
                void'(fifo_q.pop_front());
            end
        end
        #1;
    endtask

    task automatic write_word(input logic [DSIZE-1:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fifo_rinc", fifo_rinc, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_out_data", out_data, 0);
        fifo_q.delete();
        repeat (2) cycle(1'b0, 1'b0);
        chk("rst_hold_rinc", fifo_rinc, 0);
        rrst = 1'b0;
    endtask

    // Monitor: whenever the DUT presents a word it must match the head of
    // the scoreboard; a handshake retires that entry.
    initial begin
        forever begin
            @(negedge rclk);
            #1;
            if (!rrst && out_valid) begin
                if (sb.size() == 0) begin
                    chk("data_unexpected", out_data, 32'hFFFF_FFFF);
                end else begin
                    chk("out_data", out_data, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // Reference model: tracks buffer occupancy, mode and counters from the
    // behavioural rules and feeds words bound for downstream into sb.
    initial begin
        bit exp_valid, exp_rinc, hs;
        forever begin
            @(negedge rclk);
            #2;
            if (rrst) begin
                m_cnt = 0; m_wc = 0; m_flush = 0; m_done = 0;
                sb.delete();
            end else begin
                exp_valid = !m_flush && (m_cnt != 0);
                exp_rinc  = !fifo_rempty && (m_flush || m_cnt < 2);
                chk("out_valid", out_valid, exp_valid);
                chk("fifo_rinc", fifo_rinc, exp_rinc);
                chk("flush_done", flush_done, m_done);
                chk("word_count", word_count, m_wc);
                hs = exp_valid && out_ready;
                m_done = 0;
                if (hs) begin
                    m_cnt--;
                    m_wc = (m_wc + 1) % (1 << CNT_W);
                end
                if (!m_flush) begin
                    if (flush) begin
                        m_flush = 1;
                        m_cnt   = 0;
                        sb.delete();
                    end else if (exp_rinc) begin
                        sb.push_back(fifo_rdata);
                        m_cnt++;
                    end
                end else if (fifo_rempty) begin
                    m_flush = 0;
                    m_done  = 1;
                end
            end
        end
    end

    initial begin
        int pops0;
        int wc0;
        logic [DSIZE-1:0] words [4];
        words[0] = 8'hAA; words[1] = 8'hBB; words[2] = 8'hCC; words[3] = 8'hDD;

        rrst = 1'b1;
        fifo_rdata = '0;
        fifo_rempty = 1'b1;
        out_ready = 1'b0;
        flush = 1'b0;
        #1;
        do_reset();

        // basic pass-through
        for (int i = 0; i < 4; i++) write_word(words[i]);
        repeat (8) cycle(1'b1, 1'b0);
        chk("pass_count", word_count, 4);

        // backpressure: only two pops, head held stable
        for (int i = 0; i < 5; i++) write_word(8'h50 + 8'(i));
        pops0 = total_pops;
        repeat (6) cycle(1'b0, 1'b0);
        chk("bp_pops", total_pops - pops0, 2);
        chk("bp_rinc", fifo_rinc, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", out_data, 8'h50);
        repeat (8) cycle(1'b1, 1'b0);
        chk("bp_count", word_count, 9);

        // empty protection
        repeat (20) cycle(1'b1, 1'b0);
        write_word(8'h11);
        pops0 = total_pops;
        repeat (4) cycle(1'b1, 1'b0);
        chk("empty_pops", total_pops - pops0, 1);

        // flush with two buffered words and eight queued in the FIFO
        write_word(8'h61); write_word(8'h62);
        repeat (3) cycle(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) write_word(8'h70 + 8'(i));
        wc0 = int'(word_count);
        pops0 = total_pops;
        cycle(1'b0, 1'b1);
        chk("flush_valid", out_valid, 0);
        repeat (12) cycle(1'b0, 1'b0);
        chk("flush_pops", total_pops - pops0, 8);
        chk("flush_wc", word_count, wc0);
        write_word(8'h22);
        repeat (4) cycle(1'b1, 1'b0);

        // flush on an already-empty FIFO
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0);

        // counter wrap
        do_reset();
        for (int i = 0; i < 17; i++) write_word(8'(i + 1));
        repeat (22) cycle(1'b1, 1'b0);
        chk("wrap_count", word_count, 1);

        // reset mid-stream with a full buffer
        for (int i = 0; i < 5; i++) write_word(8'h90 + 8'(i));
        repeat (4) cycle(1'b0, 1'b0);
        chk("mid_full_valid", out_valid, 1);
        do_reset();
        write_word(8'h33); write_word(8'h44);
        repeat (5) cycle(1'b1, 1'b0);
        chk("mid_after_count", word_count, 2);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 45 && fifo_q.size() < 16)
                write_word(8'($urandom));
            cycle(($urandom % 4) != 0, $urandom_range(0, 99) < 3);
        end
        repeat (30) cycle(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for `async_fifo`, clocked in the read domain. It pops words from the FIFO read port into a 2-entry output buffer and presents them downstream on a valid/ready stream. It keeps a running count of delivered words. A flush mechanism discards buffered data and drains the FIFO until it is empty.

## Interface
Parameters:
- DSIZE, 8, data width; matches async_fifo DSIZE
- CNT_W, 16, width of delivered-word counter

Ports:
- rclk  input  1  read-domain clock; all state updates on rising edge
- rrst  input  1  asynchronous, active-high reset
- fifo_rdata  input  DSIZE  FIFO head word; valid whenever fifo_rempty=0
- fifo_rempty  input  1  FIFO empty flag, already synchronous to rclk
- fifo_rinc  output  1  pop strobe; a rising rclk edge with fifo_rinc=1 consumes the head word
- out_data  output  DSIZE  buffer head word
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data at the rclk edge
- flush  input  1  single-cycle flush request
- flush_done  output  1  1-cycle pulse when the flush completes
- word_count  output  CNT_W  number of completed out_valid&out_ready handshakes

## Operation
- The block holds two states: RUN and FLUSH. Reset enters RUN.
- The output buffer is a 2-entry FIFO of registers with cnt in 0..2.
  - out_valid = (cnt != 0).
  - out_data = entry at the buffer head.
- RUN pop rule: fifo_rinc = !rrst && !fifo_rempty && (cnt < 2).
  - The rule is combinational on registered state and fifo_rempty only. It never depends on out_ready.
- On an edge with fifo_rinc=1, fifo_rdata is written to the buffer tail.
- On an edge with out_valid && out_ready:
  - The head is removed.
  - word_count increments by 1, modulo 2^CNT_W, wrapping silently.
- Simultaneous push and pop: cnt is unchanged and data order is preserved.
  - With cnt=1, the new word becomes the head on the next cycle.
- fifo_rinc is never 1 while fifo_rempty=1. The block never underflows the FIFO.
- Transition RUN→FLUSH on flush=1:
  - cnt is cleared to 0 at that edge, so buffered words are discarded.
  - A handshake completing on the same edge still counts.
  - A word popped on the same edge is discarded.
- FLUSH behaviour:
  - out_valid = 0.
  - fifo_rinc = !fifo_rempty.
  - Words read from the FIFO are discarded and word_count is unchanged.
- Transition FLUSH→RUN on the first edge where fifo_rempty=1 is sampled.
  - flush_done = 1 for the cycle after that edge.
- flush asserted while in FLUSH is ignored. flush asserted in the flush_done cycle starts a new flush.

## Timing
- Reset values (asynchronous, on rrst=1):
  - state=RUN, cnt=0, out_valid=0, out_data=0, word_count=0, flush_done=0.
  - fifo_rinc is held at 0 for the whole time rrst=1.
- Pop-to-valid latency: out_valid rises in the cycle after the edge where fifo_rinc=1.
- Throughput: 1 word/cycle when the FIFO is non-empty and out_ready=1 is held (steady state cnt=1).
- Backpressure (out_ready=0):
  - cnt reaches 2 and fifo_rinc drops the same cycle.
  - No word is lost. out_data stays stable while out_valid=1 and out_ready=0.
- out_valid never depends combinationally on out_ready.
- FLUSH on an already-empty FIFO: FLUSH lasts 1 cycle and flush_done pulses on the next cycle.
- Reset mid-transfer or mid-flush drops buffer contents immediately. Any word popped on that edge is lost. Resetting the FIFO itself is the system's responsibility.

## Test plan
- Basic pass-through: after reset, push 0xAA, 0xBB, 0xCC, 0xDD into async_fifo with out_ready=1.
  - Expect out_data to deliver AA, BB, CC, DD in order, each 1 cycle after its fifo_rinc edge.
  - Expect word_count=4 at the end.
- Backpressure: FIFO holds 5 words and out_ready=0.
  - Expect exactly 2 pops, cnt=2, fifo_rinc=0, out_data=first word held stable.
  - Release out_ready; expect all 5 words delivered in order with no gaps once streaming.
- Empty protection: hold fifo_rempty=1 for 20 cycles.
  - Expect fifo_rinc=0 and out_valid=0 throughout.
  - Write 0x11; expect exactly one pop and 0x11 delivered.
- Flush: with 8 words in the FIFO, 2 words buffered and out_ready=0, pulse flush.
  - Expect out_valid=0 the next cycle and 8 further pops.
  - Expect flush_done 1 cycle after rempty is sampled high, and word_count unchanged.
  - Then write 0x22; expect 0x22 delivered.
- Counter wrap with CNT_W=4: deliver 17 words; expect word_count=1.
- Reset mid-stream: assert rrst with cnt=2.
  - Expect out_valid, fifo_rinc and word_count at 0 immediately (asynchronously).
  - After release, expect normal operation on fresh writes.
